npuf_eval_ctrl: RTL and testbench
=================================

Name: npuf_eval_ctrl

Overview:
Sequencer that drives the npuf arbiter array and collects its responses. It captures a seed challenge and a length, then repeats a fixed sequence: apply challenge, hold the PUF reset, release it, wait for the output to settle, and sample. Each response bit is a majority vote over several evaluations. Challenges advance via a 128-bit LFSR. Bits accumulate into a word returned over a valid/ready handshake. Sits between the host/wishbone register block (upstream) and npuf (downstream).

Parameters:
RST_CYCLES, 8, cycles puf_reset held high per evaluation (>=1)
SETTLE_CYCLES, 64, cycles after release before sampling (>=3, covers 2-flop sync)
VOTE_N, 3, evaluations per response bit (odd, >=1)
RESP_W, 32, response bits per word (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; accepted only in IDLE
cfg_length  in  2  PUF length select; captured on accepted start
seed  in  128  initial challenge; captured on accepted start
busy  out  1  high in every state except IDLE
puf_reset  out  1  to npuf reset; 1 holds arbiters
puf_length  out  2  to npuf length; constant for a whole word
puf_c  out  128  to npuf c
puf_out  in  1  npuf out; asynchronous, passed through a 2-flop synchronizer
resp_data  out  RESP_W  response word; first bit evaluated lands in MSB
resp_valid  out  1  response word available
resp_ready  in  1  consumer accepts word

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: puf_reset=1, puf_c=0, puf_length=0, resp_data=0, resp_valid=0, busy=0, synchronizer=0, state=IDLE.
- Reset mid-operation: the next cycle is IDLE with all reset values restored. The partial word is discarded and no resp_valid is issued.
- States: IDLE, LOAD, HOLD, SETTLE, SAMPLE, NEXT, OUT.
- IDLE:
  - puf_reset=1.
  - On start=1, capture cfg_length into puf_length and go to LOAD.
  - Capture seed; seed==0 is replaced by 128'h1 to avoid LFSR lockup.
- LOAD (1 cycle): puf_c <= captured seed; clear the vote counter, bit counter and shift register. Go to HOLD.
- HOLD (RST_CYCLES cycles): puf_reset=1. Go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles): puf_reset=0. Go to SAMPLE.
- SAMPLE (1 cycle):
  - puf_reset=0.
  - Increment the ones-count if the synchronized puf_out is 1; increment the vote index.
  - If vote index < VOTE_N, go to HOLD with the same challenge.
  - Otherwise go to NEXT.
- NEXT (1 cycle):
  - Response bit = (ones-count > VOTE_N/2). Shift it in: shreg <= {shreg[RESP_W-2:0], bit}.
  - Clear vote state and advance the challenge: puf_c <= {puf_c[126:0],1'b0} ^ (puf_c[127] ? 128'h28000005 : 0), i.e. Galois x^128+x^29+x^27+x^2+1.
  - If RESP_W bits are done, load resp_data and go to OUT; otherwise go to HOLD.
- OUT:
  - resp_valid=1; resp_data is stable while resp_valid=1 && !resp_ready.
  - When resp_valid && resp_ready, the word is transferred; the next cycle is IDLE with resp_valid=0.
  - puf_reset=1.
- start while busy is ignored (no queueing).
- Latency: with start accepted in cycle T0, the first resp_valid cycle is T0 + 2 + RESP_W*(VOTE_N*(RST_CYCLES+SETTLE_CYCLES+1)+1).
- cfg_length=2'b11 is passed through unchanged; npuf treats it as 128.
- The full 128-bit LFSR always steps regardless of length; npuf uses only the low bits it needs.

Decomposition:
- Package npuf_ctrl_pkg holds:
  - state enum type;
  - LFSR tap constant 128'h28000005;
  - default timing constants;
  - nonzero seed-replacement constant.
- One sub-module, npuf_lfsr128: combinational next-state function of the challenge, reused by the bench model.

Test Plan:
All scenarios use RESP_W=4, RST_CYCLES=2, SETTLE_CYCLES=4, VOTE_N=3 unless noted.
1. Assert reset for 2 cycles -> puf_reset=1, resp_valid=0, busy=0, puf_c=0, resp_data=0.
2. start at T0 with seed=128'h1, puf_out held at 1 -> resp_valid first high at T0+90, resp_data=4'hF. puf_c steps 1,2,4,8. puf_reset pattern is 2 cycles high, 5 low, repeated 12 times.
3. Votes driven 1,0,1 for bit0, 0,0,1 for bit1, 1,1,1 for bit2, 0,0,0 for bit3 -> resp_data=4'b1010.
4. seed=128'h8000…0 -> second challenge is 128'h28000005. seed=0 -> first challenge is 128'h1.
5. Hold resp_ready=0 for 10 cycles in OUT and pulse start -> resp_data stable, busy=1, start ignored. Raise resp_ready -> one transfer, then IDLE.
6. Assert reset during SETTLE of bit 2 -> next cycle IDLE, puf_reset=1. A new start then produces a full fresh word with no residue from the aborted run.

Source files
------------

// File: rtl/npuf_ctrl_pkg.sv
// Shared types and constants for the npuf evaluation sequencer.
package npuf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_NEXT,
        ST_OUT
    } state_t;

    // Galois taps for x^128 + x^29 + x^27 + x^2 + 1
    localparam logic [127:0] LFSR_TAPS    = 128'h28000005;
    localparam logic [127:0] SEED_NONZERO = 128'h1;

    localparam int DEF_RST_CYCLES    = 8;
    localparam int DEF_SETTLE_CYCLES = 64;
    localparam int DEF_VOTE_N        = 3;
    localparam int DEF_RESP_W        = 32;

endpackage

// File: rtl/npuf_lfsr128.sv
// One Galois step of the 128-bit challenge LFSR (purely combinational).
module npuf_lfsr128
    import npuf_ctrl_pkg::*;
(
    input  logic [127:0] cur,
    output logic [127:0] nxt
);

    assign nxt = {cur[126:0], 1'b0} ^ (cur[127] ? LFSR_TAPS : 128'h0);

endmodule

// File: rtl/npuf_eval_ctrl.sv
// Sequences npuf evaluations (hold, settle, sample), majority-votes each bit
// and returns RESP_W-bit words over a valid/ready handshake.
module npuf_eval_ctrl
    import npuf_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int VOTE_N        = DEF_VOTE_N,
    parameter int RESP_W        = DEF_RESP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cfg_length,
    input  logic [127:0]      seed,
    output logic              busy,
    output logic              puf_reset,
    output logic [1:0]        puf_length,
    output logic [127:0]      puf_c,
    input  logic              puf_out,
    output logic [RESP_W-1:0] resp_data,
    output logic              resp_valid,
    input  logic              resp_ready
);

    localparam int TMR_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int VOTE_W  = $clog2(VOTE_N + 1);
    localparam int BIT_W   = $clog2(RESP_W + 1);

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   tmr;
    logic [VOTE_W-1:0]  vote_idx;
    logic [VOTE_W-1:0]  ones;
    logic [BIT_W-1:0]   bit_cnt;
    logic [RESP_W-1:0]  shreg;
    logic [RESP_W-1:0]  shreg_nxt;
    logic [127:0]       seed_q;
    logic [127:0]       puf_c_nxt;
    logic [1:0]         sync;
    logic               vote_bit;
    logic               last_vote;
    logic               last_bit;

    npuf_lfsr128 u_lfsr (
        .cur (puf_c),
        .nxt (puf_c_nxt)
    );

    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_OUT);
    assign last_vote  = (int'(vote_idx) + 1 >= VOTE_N);
    assign last_bit   = (int'(bit_cnt) + 1 >= RESP_W);
    assign vote_bit   = (int'(ones) > VOTE_N / 2);
    // Shift form keeps RESP_W == 1 legal; first evaluated bit ends in the MSB
    assign shreg_nxt  = (shreg << 1) | RESP_W'(vote_bit);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_HOLD;
            ST_HOLD:   if (tmr == TMR_W'(RST_CYCLES - 1)) state_nxt = ST_SETTLE;
            ST_SETTLE: if (tmr == TMR_W'(SETTLE_CYCLES - 1)) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = last_vote ? ST_NEXT : ST_HOLD;
            ST_NEXT:   state_nxt = last_bit ? ST_OUT : ST_HOLD;
            ST_OUT:    if (resp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            vote_idx   <= '0;
            ones       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            seed_q     <= '0;
            puf_c      <= '0;
            puf_length <= '0;
            resp_data  <= '0;
            sync       <= '0;
            puf_reset  <= 1'b1;
        end else begin
            state <= state_nxt;
            sync  <= {sync[0], puf_out};
            // Registered from the next state so the arbiter reset never glitches
            puf_reset <= !(state_nxt == ST_SETTLE || state_nxt == ST_SAMPLE);

            if (state_nxt != state)
                tmr <= '0;
            else if (state == ST_HOLD || state == ST_SETTLE)
                tmr <= tmr + TMR_W'(1);

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        puf_length <= cfg_length;
                        seed_q     <= (seed == 128'h0) ? SEED_NONZERO : seed;
                    end
                end
                ST_LOAD: begin
                    puf_c    <= seed_q;
                    vote_idx <= '0;
                    ones     <= '0;
                    bit_cnt  <= '0;
                    shreg    <= '0;
                end
                ST_SAMPLE: begin
                    ones     <= ones + VOTE_W'(sync[1]);
                    vote_idx <= vote_idx + VOTE_W'(1);
                end
                ST_NEXT: begin
                    shreg    <= shreg_nxt;
                    ones     <= '0;
                    vote_idx <= '0;
                    puf_c    <= puf_c_nxt;
                    bit_cnt  <= bit_cnt + BIT_W'(1);
                    if (last_bit) resp_data <= shreg_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_npuf_eval_ctrl.sv
// Randomized bench for npuf_eval_ctrl against a cycle-schedule reference model.
module tb_npuf_eval_ctrl;

    localparam int RW  = 4;
    localparam int RC  = 2;
    localparam int SC  = 4;
    localparam int VN  = 3;
    localparam int PER_VOTE = RC + SC + 1;
    localparam int PER_BIT  = VN * PER_VOTE + 1;
    localparam int LAT      = 2 + RW * PER_BIT;

    logic          clk = 1'b0;
    logic          reset, start, resp_ready;
    logic [1:0]    cfg_length;
    logic [127:0]  seed;
    logic          busy, puf_reset, resp_valid;
    logic [1:0]    puf_length;
    logic [127:0]  puf_c;
    logic          puf_out;
    logic [RW-1:0] resp_data;

    npuf_eval_ctrl #(
        .RST_CYCLES    (RC),
        .SETTLE_CYCLES (SC),
        .VOTE_N        (VN),
        .RESP_W        (RW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_length (cfg_length),
        .seed       (seed),
        .busy       (busy),
        .puf_reset  (puf_reset),
        .puf_length (puf_length),
        .puf_c      (puf_c),
        .puf_out    (puf_out),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 = idle, 1 = running (n = cycles since accepted start), 2 = word offered
    int           mode = 0;
    int           n = 0;
    logic         after_rst = 1'b0;
    logic         chk_en = 1'b0;
    logic [1:0]   len_q = 2'b00;
    logic [127:0] seed_q = 128'h0;
    bit           votes [RW][VN];
    logic [127:0] pc_seen [RW];
    int           lowcnt = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] lfsr_adv(input logic [127:0] c, input int k);
        logic [127:0] r;
        r = c;
        for (int i = 0; i < k; i++)
            r = r[127] ? ((r << 1) ^ 128'h28000005) : (r << 1);
        return r;
    endfunction

    function automatic logic [RW-1:0] exp_word();
        logic [RW-1:0] w;
        int cnt;
        w = '0;
        for (int b = 0; b < RW; b++) begin
            cnt = 0;
            for (int v = 0; v < VN; v++) cnt += int'(votes[b][v]);
            w[RW-1-b] = (2 * cnt > VN);
        end
        return w;
    endfunction

    function automatic logic exp_rst();
        int r;
        if (mode != 1 || n < 2) return 1'b1;
        r = (n - 2) % PER_BIT;
        if (r == PER_BIT - 1) return 1'b1;
        return ((r % PER_VOTE) < RC);
    endfunction

    // Response source: each evaluation window presents its vote from HOLD onward
    always_comb begin
        int k, b, v;
        puf_out = 1'b0;
        k = 0; b = 0; v = 0;
        if (mode == 1 && n >= 2 && n < LAT) begin
            k = n - 2;
            b = k / PER_BIT;
            v = (k % PER_BIT) / PER_VOTE;
            if (v >= VN) v = VN - 1;
            puf_out = votes[b][v];
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            mode      <= 0;
            n         <= 0;
            after_rst <= 1'b1;
            chk_en    <= 1'b1;
        end else begin
            case (mode)
                0: if (start) begin
                    mode      <= 1;
                    n         <= 1;
                    len_q     <= cfg_length;
                    seed_q    <= (seed == 128'h0) ? 128'h1 : seed;
                    after_rst <= 1'b0;
                end
                1: begin
                    n <= n + 1;
                    if (n + 1 == LAT) mode <= 2;
                end
                default: if (resp_ready) mode <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 128'(busy), 128'(mode != 0));
            check("resp_valid", 128'(resp_valid), 128'(mode == 2));
            check("puf_reset", 128'(puf_reset), 128'(exp_rst()));
            if (mode != 0) check("puf_length", 128'(puf_length), 128'(len_q));
            if (mode == 1 && n >= 2) begin
                check("puf_c", puf_c, lfsr_adv(seed_q, (n - 2) / PER_BIT));
                if ((n - 2) % PER_BIT == 0) pc_seen[(n - 2) / PER_BIT] = puf_c;
            end
            if (mode == 1 && !puf_reset) lowcnt++;
            if (mode == 2) begin
                check("out_puf_c", puf_c, lfsr_adv(seed_q, RW));
                check("resp_data", 128'(resp_data), 128'(exp_word()));
            end
            if (mode == 0 && after_rst) begin
                check("rst_puf_c", puf_c, 128'h0);
                check("rst_resp_data", 128'(resp_data), 128'h0);
                check("rst_puf_length", 128'(puf_length), 128'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_votes(input logic [RW*VN-1:0] pat);
        for (int b = 0; b < RW; b++)
            for (int v = 0; v < VN; v++)
                votes[b][v] = pat[(RW - 1 - b) * VN + (VN - 1 - v)];
    endtask

    task automatic rand_votes();
        for (int b = 0; b < RW; b++)
            for (int v = 0; v < VN; v++)
                votes[b][v] = bit'($urandom_range(0, 1));
    endtask

    task automatic run_word(input logic [127:0] s, input logic [1:0] l, input int rdy_delay,
                            input bit pulse_busy, output int lat, output logic [RW-1:0] data);
        for (int i = 0; i < RW; i++) pc_seen[i] = '0;
        lowcnt     = 0;
        cfg_length = l;
        seed       = s;
        start      = 1'b1;
        step();
        start = 1'b0;
        lat   = 1;
        while (!resp_valid && lat < 400) begin
            start = pulse_busy && ($urandom_range(0, 15) == 0);
            cfg_length = 2'($urandom_range(0, 3));
            seed  = {$urandom, $urandom, $urandom, $urandom};
            step();
            lat++;
        end
        start = 1'b0;
        check("valid_seen", 128'(resp_valid), 128'h1);
        data = resp_data;
        for (int i = 0; i < rdy_delay; i++) begin
            start = pulse_busy && ($urandom_range(0, 1) == 1);
            step();
            check("hold_data", 128'(resp_data), 128'(data));
            check("hold_busy", 128'(busy), 128'h1);
        end
        start      = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("xfer_idle_busy", 128'(busy), 128'h0);
        check("xfer_idle_valid", 128'(resp_valid), 128'h0);
    endtask

    initial begin
        int lat;
        logic [RW-1:0] data;

        reset = 1'b1; start = 1'b0; resp_ready = 1'b0;
        cfg_length = 2'b00; seed = '0;
        set_votes('0);
        step();
        step();
        check("reset_puf_reset", 128'(puf_reset), 128'h1);
        check("reset_valid", 128'(resp_valid), 128'h0);
        check("reset_busy", 128'(busy), 128'h0);
        check("reset_puf_c", puf_c, 128'h0);
        check("reset_data", 128'(resp_data), 128'h0);
        reset = 1'b0;
        step();

        // All-ones responses from seed 1
        set_votes('1);
        run_word(128'h1, 2'b01, 0, 1'b0, lat, data);
        check("latency", 128'(lat), 128'd90);
        check("word_all_ones", 128'(data), 128'hF);
        check("chal0", pc_seen[0], 128'h1);
        check("chal1", pc_seen[1], 128'h2);
        check("chal2", pc_seen[2], 128'h4);
        check("chal3", pc_seen[3], 128'h8);
        check("reset_low_cycles", 128'(lowcnt), 128'd60);

        // Majority per bit: 101, 001, 111, 000
        set_votes(12'b101_001_111_000);
        run_word({$urandom, $urandom, $urandom, $urandom}, 2'b11, 2, 1'b1, lat, data);
        check("word_vote", 128'(data), 128'hA);

        // MSB seed exercises the feedback taps; zero seed is replaced
        rand_votes();
        run_word({1'b1, 127'h0}, 2'b10, 0, 1'b0, lat, data);
        check("chal_taps", pc_seen[1], 128'h28000005);
        rand_votes();
        run_word(128'h0, 2'b00, 0, 1'b0, lat, data);
        check("zero_seed", pc_seen[0], 128'h1);

        // Back-pressure with start pulses while the word is held
        set_votes(12'b110_010_100_011);
        run_word({$urandom, $urandom, $urandom, $urandom}, 2'b01, 10, 1'b1, lat, data);
        check("word_backpressure", 128'(data), 128'h9);
        step();
        check("stays_idle", 128'(busy), 128'h0);

        // Abort in SETTLE of bit 2, then a fresh word
        set_votes('1);
        cfg_length = 2'b10;
        seed  = 128'h5;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2 + 2 * PER_BIT + RC - 1) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 128'(busy), 128'h0);
        check("abort_puf_reset", 128'(puf_reset), 128'h1);
        check("abort_valid", 128'(resp_valid), 128'h0);
        check("abort_puf_c", puf_c, 128'h0);
        step();
        set_votes(12'b000_111_011_001);
        run_word(128'h3, 2'b01, 1, 1'b0, lat, data);
        check("fresh_latency", 128'(lat), 128'd90);
        check("fresh_word", 128'(data), 128'h6);

        // Randomized words
        for (int w = 0; w < 8; w++) begin
            rand_votes();
            run_word(($urandom_range(0, 7) == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom},
                     2'($urandom_range(0, 3)), $urandom_range(0, 6), 1'b1, lat, data);
            check("rand_latency", 128'(lat), 128'(LAT));
            check("rand_word", 128'(data), 128'(exp_word()));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
